// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared state type and sizing helpers for the tone player
//
// Purpose: state encoding and elaboration-time helpers used by tone_player
//          and ms_tick_gen.
// Ports:   none (package).
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

  // Clock cycles per millisecond; FCLK is a multiple of 1000.
  function automatic int ticks_per_ms(input int fclk);
    return fclk / 1000;
  endfunction

  // acc < FCLK and 2*freq <= FCLK, so acc + 2*freq < 2*FCLK always fits
  // with one bit of headroom above clog2(2*FCLK).
  function automatic int acc_width(input int fclk);
    return $clog2(2 * fclk) + 1;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_player_if.sv
// rtl/tone_player_if.sv - tone request handshake bundle
//
// Purpose: groups the valid/ready tone request channel.
// Signals: req_valid  request present (master -> slave)
//          req_ready  slave can accept (slave -> master)
//          req_freq   tone frequency in Hz, 0 = rest
//          req_dur_ms tone duration in ms
interface tone_player_if #(
  parameter int FREQ_W = 20,
  parameter int DUR_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [FREQ_W-1:0] req_freq;
  logic [DUR_W-1:0]  req_dur_ms;

  modport master (
    output req_valid,
    output req_freq,
    output req_dur_ms,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_freq,
    input  req_dur_ms,
    output req_ready
  );
endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler with synchronous restart
//
// Purpose: counts 0..TICKS-1 and pulses ms_tick on the last count.
// Ports:   clk     system clock
//          reset   asynchronous active-high reset
//          clr     synchronous restart; counter is 0 on the following cycle
//          ms_tick one-cycle pulse every TICKS cycles after a restart
module ms_tick_gen import tone_pkg::*; #(
  parameter int TICKS = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic ms_tick
);

  localparam int CW = cnt_width(TICKS);

  logic [CW-1:0] cnt;

  assign ms_tick = (cnt == CW'(TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || ms_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tone_player.sv
// rtl/tone_player.sv - single-voice timed square-wave tone player
//
// Purpose: accepts (frequency, duration) requests, plays a phase-accumulated
//          square wave for the duration, holds a fixed silent gap, then
//          pulses done.
// Ports:   clk    system clock, FCLK Hz
//          reset  asynchronous active-high reset
//          req    tone_player_if.slave request channel (ready only in IDLE)
//          abort  cancel the current tone/gap, no done pulse
//          spkr   square-wave speaker output
//          busy   high while playing or in the gap
//          done   one-cycle pulse on the first IDLE cycle after completion
module tone_player import tone_pkg::*; #(
  parameter int FCLK   = 50_000_000,
  parameter int FREQ_W = 20,
  parameter int DUR_W  = 16,
  parameter int GAP_MS = 20
) (
  input  logic          clk,
  input  logic          reset,
  tone_player_if.slave  req,
  input  logic          abort,
  output logic          spkr,
  output logic          busy,
  output logic          done
);

  localparam int TICKS = ticks_per_ms(FCLK);
  localparam int ACC_W = acc_width(FCLK);
  localparam int FHALF = FCLK / 2;
  // One counter serves both the duration and the gap.
  localparam int MS_W  = max_int(DUR_W, cnt_width(GAP_MS + 1));

  tone_state_t       state, state_nx;
  logic [ACC_W-1:0]  acc, acc_nx, acc_sum;
  logic [ACC_W-1:0]  freq_l, freq_in;
  logic [DUR_W-1:0]  dur_l;
  logic [MS_W-1:0]   ms_cnt;
  logic [FREQ_W-1:0] req_f;
  logic              ms_tick, clr, accept;
  logic              play_last, gap_last;
  logic              spkr_nx, done_nx;

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = (state == IDLE) && req.req_valid;
  assign req_f         = req.req_freq;

  // Prescaler restarts on every state change so each PLAY/GAP phase spans
  // whole milliseconds measured from its first cycle; held clear in IDLE.
  assign clr = (state == IDLE) || (state_nx != state);

  ms_tick_gen #(.TICKS(TICKS)) u_ms_tick (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .ms_tick (ms_tick)
  );

  // dur_l is nonzero whenever PLAY is entered.
  assign play_last = ms_tick && (ms_cnt == MS_W'(dur_l) - MS_W'(1));
  // GAP is unreachable when GAP_MS == 0, so the wrapped constant is harmless.
  assign gap_last  = ms_tick && (ms_cnt == MS_W'(GAP_MS - 1));

  // Frequencies above Nyquist of the toggle rate are clamped.
  always_comb begin
    freq_in = ACC_W'(req_f);
    if (64'(req_f) > 64'(FHALF)) begin
      freq_in = ACC_W'(FHALF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req.req_dur_ms != '0) begin
            state_nx = PLAY;
          end else if (GAP_MS != 0) begin
            state_nx = GAP;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      PLAY: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (play_last) begin
          if (GAP_MS != 0) begin
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // 2*freq_l <= FCLK and acc < FCLK, so a single subtraction keeps acc in
  // range and the remainder carries into the next half-period.
  assign acc_sum = acc + (freq_l << 1);

  always_comb begin
    acc_nx  = acc;
    spkr_nx = 1'b0;
    if (accept) begin
      acc_nx = '0;
    end else if ((state == PLAY) && (freq_l != '0)) begin
      if (acc_sum >= ACC_W'(FCLK)) begin
        acc_nx  = acc_sum - ACC_W'(FCLK);
        spkr_nx = ~spkr;
      end else begin
        acc_nx  = acc_sum;
        spkr_nx = spkr;
      end
    end
    // Never leave the speaker high outside PLAY.
    if (state_nx != PLAY) begin
      spkr_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      spkr   <= 1'b0;
      done   <= 1'b0;
      freq_l <= '0;
      dur_l  <= '0;
      ms_cnt <= '0;
    end else begin
      acc  <= acc_nx;
      spkr <= spkr_nx;
      done <= done_nx;
      if (accept) begin
        freq_l <= freq_in;
        dur_l  <= req.req_dur_ms;
      end
      if (clr) begin
        ms_cnt <= '0;
      end else if (ms_tick) begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end
    end
  end

endmodule

// File: doc/tone_player.md
Name: tone_player

Overview:
- Single-voice tone player for the game's speaker path.
- Accepts tone requests (frequency in Hz, duration in ms) over a valid/ready handshake.
- Generates a phase-accumulated square wave for the requested duration, then enforces a fixed silent gap and pulses done.
- Sits between the game FSM / sequence playback logic and the speaker pin; replaces free-running, duration-less tone generation.

Parameters:
- FCLK, 50_000_000: clock frequency in Hz; must be a multiple of 1000.
- FREQ_W, 20: width of the request frequency field (Hz).
- DUR_W, 16: width of the request duration field (ms).
- GAP_MS, 20: silent gap after every tone, in ms; 0 means no gap.

Ports:
- clk  in  1  system clock, FCLK Hz
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_freq  in  FREQ_W  tone frequency in Hz; 0 = rest (silence for the duration)
- req_dur_ms  in  DUR_W  tone duration in ms
- abort  in  1  cancel the current tone/gap
- spkr  out  1  square-wave speaker output
- busy  out  1  high in PLAY or GAP
- done  out  1  one-cycle pulse when a request completes normally

Behaviour:
- Reset (async, active-high) values: state=IDLE, spkr=0, done=0, busy=0, req_ready=1, accumulator=0, counters=0.
- TICKS = FCLK/1000 cycles per ms. The ms prescaler counts 0..TICKS-1.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - latch freq, clamped to FCLK/2 if larger;
    - latch req_dur_ms;
    - clear accumulator, prescaler and ms counter;
    - go to PLAY, or to GAP if req_dur_ms==0.
  - PLAY: lasts exactly req_dur_ms*TICKS cycles. On the last cycle, go to GAP; if GAP_MS==0, go straight to IDLE with done.
  - GAP: spkr forced 0; lasts exactly GAP_MS*TICKS cycles, then go to IDLE.
- done: registered; high for exactly the first IDLE cycle after a normal completion, coincident with req_ready rising.
- Tone generation, PLAY only:
  - next = acc + 2*freq_l.
  - If next >= FCLK: acc <= next - FCLK and toggle spkr; else acc <= next.
  - Remainder is carried, not reset, so the long-run average frequency is exact.
  - Accumulator width: clog2(2*FCLK)+1 bits minimum; no overflow is permitted.
  - freq_l==0: spkr held 0, accumulator unchanged.
  - freq_l==FCLK/2: spkr toggles every cycle.
- spkr is forced to 0 on every exit from PLAY, so it is never left high in GAP or IDLE.
- abort:
  - In PLAY or GAP: next cycle state=IDLE, spkr=0, busy=0, no done pulse.
  - In IDLE: ignored. If req_valid is also high that cycle, the request is accepted.
- Back-to-back: a new request may be accepted on the same cycle done is high.
- Inputs are sampled only at acceptance; changes to req_* during PLAY/GAP have no effect.
- Reset mid-operation: immediate return to reset values; no done pulse.

Decomposition:
- Package tone_pkg holds:
  - state enum typedef (IDLE, PLAY, GAP);
  - function ticks_per_ms(FCLK);
  - localparam helpers for accumulator width.
- One sub-module, ms_tick_gen: parametrised prescaler with a sync clear that emits a one-cycle ms_tick. The top counts ms_tick for both the duration and gap counters.

Test Plan:
All runs use FCLK=10_000 (TICKS=10) and GAP_MS=2.
- Reset/idle: assert reset mid-PLAY -> spkr=0, busy=0, req_ready=1 immediately; done never pulses.
- Basic tone: freq=1000, dur=3, accepted at cycle 0 -> PLAY for 30 cycles; spkr toggles every 5 cycles (first toggle 5 cycles after accept, 6 toggles total); GAP for 20 cycles with spkr=0; done high for 1 cycle at cycle 51; req_ready rises with it.
- Non-integer ratio: freq=3000, dur=10 -> 100 PLAY cycles; toggle spacing alternates 1–2 cycles; exactly 60 toggles.
- Rest and zero duration:
  - freq=0, dur=2 -> spkr stays 0 for 20+20 cycles, then done.
  - dur=0 -> GAP entered directly; done after 20 cycles.
- Clamp: freq=9000 (>5000) -> spkr toggles every cycle during PLAY.
- Abort and back-to-back:
  - abort on cycle 12 of PLAY -> IDLE next cycle, spkr=0, no done.
  - Hold req_valid high continuously with two requests -> second accepted on the done cycle of the first; no idle gap beyond the GAP_MS silence.
